imem_loader_enc: RTL and testbench

IMEM_LOADER_ENC -- requirements
Module: imem_loader_enc

---
 rtl/imem_loader_enc.sv | 139 +++++++++++++
 tb/tb_imem_loader_enc.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_enc.sv
// LEGv8 instruction encoder feeding a 4-entry FIFO that writes words into instruction memory.
// Optional running XOR checksum of committed words: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader_enc (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [25:0] imm,
  input  logic [1:0]  hw,
  output logic        imem_we,
  input  logic        imem_ack,
  output logic [15:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        err,
  output logic [31:0] checksum
);

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 16;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q, rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [WORD_W-1:0] head_nxt;
  logic              err_nxt;

  logic [WORD_W-1:0] enc_word_c;
  logic              enc_legal_c;
  logic              accept_c, push_c, pop_c;

  // Instruction encoder
  always_comb begin
    enc_word_c  = '0;
    enc_legal_c = 1'b1;
    case (op_sel)
      4'd0:    enc_word_c = {11'b10001010000, rm, 6'b000000, rn, rd};
      4'd1:    enc_word_c = {11'b10101010000, rm, 6'b000000, rn, rd};
      4'd2:    enc_word_c = {11'b10001011000, rm, 6'b000000, rn, rd};
      4'd3:    enc_word_c = {11'b11001011000, rm, 6'b000000, rn, rd};
      4'd4:    enc_word_c = {10'b1001000100, imm[11:0], rn, rd};
      4'd5:    enc_word_c = {10'b1101000100, imm[11:0], rn, rd};
      4'd6:    enc_word_c = {9'b110100101, hw, imm[15:0], rd};
      4'd7:    enc_word_c = {6'b000101, imm[25:0]};
      4'd8:    enc_word_c = {8'b10110100, imm[18:0], rd};
      4'd9:    enc_word_c = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
      4'd10:   enc_word_c = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
      default: enc_legal_c = 1'b0;
    endcase
  end

  assign accept_c = in_valid && in_ready && !clear;
  assign push_c   = accept_c && enc_legal_c;
  assign pop_c    = imem_we && imem_ack && !clear;

  // Next-state: pointers, occupancy, address, sticky error and the next head word
  always_comb begin
    rd_ptr_nxt = rd_ptr_q;
    wr_ptr_nxt = wr_ptr_q;
    cnt_nxt    = cnt_q;
    addr_nxt   = imem_addr;
    err_nxt    = err;
    head_nxt   = imem_wdata;
    if (clear) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      cnt_nxt    = '0;
      addr_nxt   = '0;
      err_nxt    = 1'b0;
    end else begin
      if (pop_c) begin
        rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
        addr_nxt   = imem_addr + ADDR_W'(4);
      end
      if (push_c) begin
        wr_ptr_nxt = wr_ptr_q + PTR_W'(1);
      end
      if (accept_c && !enc_legal_c) begin
        err_nxt = 1'b1;
      end
      cnt_nxt = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
      // The only case the new head is not yet in storage is when it is being pushed now
      if (cnt_nxt != '0) begin
        head_nxt = (push_c && (wr_ptr_q == rd_ptr_nxt)) ? enc_word_c : mem[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push_c) begin
      mem[wr_ptr_q] <= enc_word_c;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      imem_we    <= 1'b0;
      in_ready   <= 1'b1;
      err        <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_nxt;
      wr_ptr_q   <= wr_ptr_nxt;
      cnt_q      <= cnt_nxt;
      imem_addr  <= addr_nxt;
      imem_wdata <= head_nxt;
      imem_we    <= (cnt_nxt != '0);
      in_ready   <= (cnt_nxt != CNT_W'(DEPTH));
      err        <= err_nxt;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      checksum <= '0;
    end else if (clear) begin
      checksum <= '0;
    end else if (pop_c) begin
      checksum <= checksum ^ imem_wdata;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader_enc.sv
// Directed bench for imem_loader_enc: queue-based reference model checked every cycle,
// plus literal expectations for known encodings and handshake corner cases.
module tb_imem_loader_enc;

  logic        CLK = 1'b0;
  logic        resetl, clear, in_valid, in_ready, imem_we, imem_ack, err;
  logic [3:0]  op_sel;
  logic [4:0]  rd, rn, rm;
  logic [25:0] imm;
  logic [1:0]  hw;
  logic [15:0] imem_addr;
  logic [31:0] imem_wdata, checksum;

  int n_tests = 0;
  int n_fail  = 0;

  imem_loader_enc dut (
    .CLK(CLK), .resetl(resetl), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .hw(hw),
    .imem_we(imem_we), .imem_ack(imem_ack), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .err(err), .checksum(checksum)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from opcode constants and shifts
  function automatic logic [31:0] model_enc(input logic [3:0] op, input logic [31:0] d,
      input logic [31:0] n, input logic [31:0] m, input logic [31:0] i, input logic [31:0] h);
    logic [31:0] rtype;
    rtype = (m << 16) | (n << 5) | d;
    case (op)
      4'd0:  return (32'h450 << 21) | rtype;
      4'd1:  return (32'h550 << 21) | rtype;
      4'd2:  return (32'h458 << 21) | rtype;
      4'd3:  return (32'h658 << 21) | rtype;
      4'd4:  return (32'h244 << 22) | ((i & 32'hFFF) << 10) | (n << 5) | d;
      4'd5:  return (32'h344 << 22) | ((i & 32'hFFF) << 10) | (n << 5) | d;
      4'd6:  return (32'h1A5 << 23) | (h << 21) | ((i & 32'hFFFF) << 5) | d;
      4'd7:  return (32'h5 << 26) | (i & 32'h3FF_FFFF);
      4'd8:  return (32'hB4 << 24) | ((i & 32'h7FFFF) << 5) | d;
      4'd9:  return (32'h7C2 << 21) | ((i & 32'h1FF) << 12) | (n << 5) | d;
      4'd10: return (32'h7C0 << 21) | ((i & 32'h1FF) << 12) | (n << 5) | d;
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural model: queue of pending words, address, sticky error, checksum
  logic [31:0] mq[$];
  logic [15:0] m_addr;
  logic        m_err;
  logic [31:0] m_ck;

  always @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      mq.delete();
      m_addr = 16'h0;
      m_err  = 1'b0;
      m_ck   = 32'h0;
    end else if (clear) begin
      mq.delete();
      m_addr = 16'h0;
      m_err  = 1'b0;
      m_ck   = 32'h0;
    end else begin
      int sz;
      logic [31:0] w;
      sz = mq.size();
      w  = model_enc(op_sel, 32'(rd), 32'(rn), 32'(rm), 32'(imm), 32'(hw));
      if (imem_ack && sz > 0) begin
        m_ck   = m_ck ^ mq[0];
        void'(mq.pop_front());
        m_addr = m_addr + 16'd4;
      end
      if (in_valid && sz < 4) begin
        if (op_sel <= 4'd10) mq.push_back(w);
        else m_err = 1'b1;
      end
    end
  end

  // Commit log for literal checks
  logic [31:0] log_w[$];
  logic [15:0] log_a[$];
  always @(posedge CLK) begin
    if (resetl && !clear && imem_we && imem_ack) begin
      log_w.push_back(imem_wdata);
      log_a.push_back(imem_addr);
    end
  end

  // Per-cycle comparison against the model
  bit run_cmp = 1'b0;
  always @(negedge CLK) begin
    if (run_cmp && resetl) begin
      chk("in_ready", 32'(in_ready), 32'(mq.size() < 4));
      chk("imem_we", 32'(imem_we), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("imem_wdata", imem_wdata, mq[0]);
      chk("imem_addr", 32'(imem_addr), 32'(m_addr));
      chk("err", 32'(err), 32'(m_err));
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("checksum", checksum, m_ck);
`else
      chk("checksum", checksum, 32'h0);
`endif
    end
  end

  // Present a request and hold it until accepted; returns at a falling edge with in_valid high
  task automatic send(input logic [3:0] op, input logic [4:0] d, input logic [4:0] n,
      input logic [4:0] m, input logic [25:0] i, input logic [1:0] h);
    bit acc;
    op_sel = op; rd = d; rn = n; rm = m; imm = i; hw = h;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(posedge CLK);
      acc = in_ready;
      @(negedge CLK);
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    bit done;
    done = 1'b0;
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 100 && !done; k++) begin
      if (!imem_we) done = 1'b1;
      else @(negedge CLK);
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
    log_w.delete();
    log_a.delete();
  endtask

  initial begin
    resetl = 1'b0; clear = 1'b0; in_valid = 1'b0; imem_ack = 1'b0;
    op_sel = '0; rd = '0; rn = '0; rm = '0; imm = '0; hw = '0;
    repeat (3) @(negedge CLK);
    resetl = 1'b1;
    run_cmp = 1'b1;
    @(negedge CLK);
    chk("rst_we", 32'(imem_we), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_cksum", checksum, 32'h0);

    // Single ADD
    imem_ack = 1'b1;
    send(4'd2, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0);
    idle(); wait_empty();
    chk("add_cnt", 32'(log_w.size()), 32'd1);
    if (log_w.size() >= 1) begin
      chk("add_word", log_w[0], 32'h8B030041);
      chk("add_addr", 32'(log_a[0]), 32'h0);
    end
    chk("add_next_addr", 32'(imem_addr), 32'h4);

    // ADDI then LDUR
    do_clear();
    send(4'd4, 5'd9, 5'd9, 5'd0, 26'd1, 2'd0);
    send(4'd9, 5'd10, 5'd0, 5'd0, 26'd8, 2'd0);
    idle(); wait_empty();
    chk("addi_ldur_cnt", 32'(log_w.size()), 32'd2);
    if (log_w.size() >= 2) begin
      chk("addi_word", log_w[0], 32'h91000529);
      chk("addi_addr", 32'(log_a[0]), 32'h0);
      chk("ldur_word", log_w[1], 32'hF840800A);
      chk("ldur_addr", 32'(log_a[1]), 32'h4);
    end

    // B and CBZ, checksum
    do_clear();
    send(4'd7, 5'd0, 5'd0, 5'd0, 26'h3FF_FFFF, 2'd0);
    send(4'd8, 5'd5, 5'd0, 5'd0, 26'd2, 2'd0);
    idle(); wait_empty();
    if (log_w.size() >= 2) begin
      chk("b_word", log_w[0], 32'h17FFFFFF);
      chk("cbz_word", log_w[1], 32'hB4000045);
    end else chk("b_cbz_cnt", 32'(log_w.size()), 32'd2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("cksum_lit", checksum, 32'hA3FFFFBA);
`else
    chk("cksum_lit", checksum, 32'h0);
`endif

    // MOVZ literal
    do_clear();
    send(4'd6, 5'd3, 5'd0, 5'd0, 26'h1234, 2'd2);
    idle(); wait_empty();
    if (log_w.size() >= 1) chk("movz_word", log_w[0], 32'hD2C24683);
    else chk("movz_cnt", 32'(log_w.size()), 32'd1);

    // Back-pressure: fill, then drain in order
    do_clear();
    imem_ack = 1'b0;
    for (int k = 1; k <= 4; k++) send(4'd2, 5'(k), 5'd0, 5'd0, 26'd0, 2'd0);
    chk("full_ready", 32'(in_ready), 32'h0);
    chk("full_addr", 32'(imem_addr), 32'h0);
    imem_ack = 1'b1;
    send(4'd2, 5'd5, 5'd0, 5'd0, 26'd0, 2'd0);
    idle(); wait_empty();
    chk("drain_cnt", 32'(log_w.size()), 32'd5);
    for (int k = 0; k < 5 && k < log_w.size(); k++)
      chk("drain_order", log_w[k], 32'h8B000000 | 32'(k + 1));

    // Illegal opcode
    do_clear();
    send(4'd15, 5'd1, 5'd1, 5'd1, 26'd0, 2'd0);
    idle();
    @(negedge CLK);
    chk("ill_err", 32'(err), 32'h1);
    chk("ill_we", 32'(imem_we), 32'h0);
    chk("ill_addr", 32'(imem_addr), 32'h0);
    do_clear();
    chk("ill_clr_err", 32'(err), 32'h0);

    // Clear wins over simultaneous accept and commit
    imem_ack = 1'b0;
    send(4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0);
    send(4'd1, 5'd4, 5'd5, 5'd6, 26'd0, 2'd0);
    clear = 1'b1; imem_ack = 1'b1; in_valid = 1'b1;
    @(negedge CLK);
    clear = 1'b0; in_valid = 1'b0;
    @(negedge CLK);
    chk("clr_we", 32'(imem_we), 32'h0);
    chk("clr_addr", 32'(imem_addr), 32'h0);

    // Reset with words queued
    imem_ack = 1'b0;
    for (int k = 0; k < 3; k++) send(4'd3, 5'(k), 5'd7, 5'd8, 26'd0, 2'd0);
    idle();
    log_w.delete();
    resetl = 1'b0;
    @(negedge CLK);
    resetl = 1'b1;
    @(negedge CLK);
    chk("rst2_we", 32'(imem_we), 32'h0);
    chk("rst2_addr", 32'(imem_addr), 32'h0);
    chk("rst2_ready", 32'(in_ready), 32'h1);
    imem_ack = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst2_no_commit", 32'(log_w.size()), 32'h0);

    // Address wrap with a streaming mix of all legal opcodes
    do_clear();
    for (int k = 0; k < 16383; k++)
      send(4'(k % 11), 5'(k), 5'(k >> 5), 5'(k >> 10), 26'(k * 40503), 2'(k));
    idle(); wait_empty();
    chk("wrap_pre", 32'(imem_addr), 32'hFFFC);
    send(4'd2, 5'd1, 5'd1, 5'd1, 26'd0, 2'd0);
    idle(); wait_empty();
    chk("wrap_post", 32'(imem_addr), 32'h0);
    if (log_a.size() > 0) chk("wrap_last", 32'(log_a[log_a.size() - 1]), 32'hFFFC);

    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
